// File: rtl/ball_pkg.sv
// Shared types and constants for the ball controller: FSM states, LFSR seed/taps and the
// default-width coordinate and direction types.
package ball_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1, with bit k-1 holding the x^k term.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int unsigned COORD_W_DEFAULT = 11;
    localparam int unsigned DIR_W_DEFAULT   = 5;

    typedef logic signed [COORD_W_DEFAULT-1:0] coord_t;
    typedef logic signed [DIR_W_DEFAULT-1:0]   dir_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ball_collision_unit.sv
// Combinational ball-versus-round-player test; returns whether they overlap and the corrected
// ball position and direction if they do.
module ball_collision_unit #(
    parameter int unsigned COORD_W       = 11,
    parameter int unsigned DIR_W         = 5,
    parameter int          PLAYER_RADIUS = 20,
    parameter int          BALL_RADIUS   = 8,
    parameter int          SIDE_MARGIN   = 28,
    parameter int          PUSH          = 5
) (
    input  logic signed [COORD_W-1:0] ball_x,
    input  logic signed [COORD_W-1:0] ball_y,
    input  logic signed [DIR_W-1:0]   x_dir,
    input  logic signed [DIR_W-1:0]   y_dir,
    input  logic        [COORD_W-1:0] player_x,
    input  logic        [COORD_W-1:0] player_y,
    input  logic                      rnd,
    output logic                      hit,
    output logic signed [COORD_W-1:0] next_x,
    output logic signed [COORD_W-1:0] next_y,
    output logic signed [DIR_W-1:0]   next_x_dir,
    output logic signed [DIR_W-1:0]   next_y_dir
);

    localparam int unsigned DW = COORD_W + 1;
    localparam int unsigned SW = 2 * DW;
    localparam int          HIT_DIST = PLAYER_RADIUS + BALL_RADIUS + 2;

    localparam logic        [SW:0]        HIT_DIST_SQ = (SW + 1)'(HIT_DIST * HIT_DIST);
    localparam logic signed [DW-1:0]      MARGIN_POS  = DW'(SIDE_MARGIN);
    localparam logic signed [DW-1:0]      MARGIN_NEG  = DW'(-SIDE_MARGIN);
    localparam logic signed [COORD_W-1:0] PUSH_C      = COORD_W'(PUSH);

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic signed [SW-1:0] dx_sq;
    logic signed [SW-1:0] dy_sq;
    logic        [SW:0]   dist_sq;

    // Player coordinates are unsigned; widen both sides by one bit before subtracting.
    assign dx      = {ball_x[COORD_W-1], ball_x} - {1'b0, player_x};
    assign dy      = {ball_y[COORD_W-1], ball_y} - {1'b0, player_y};
    assign dx_sq   = dx * dx;
    assign dy_sq   = dy * dy;
    assign dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
    assign hit     = dist_sq < HIT_DIST_SQ;

    always_comb begin
        next_x     = ball_x;
        next_y     = ball_y;
        next_x_dir = x_dir;
        next_y_dir = y_dir;
        if (dx > MARGIN_POS) begin
            next_x_dir = -x_dir;
            next_x     = ball_x + PUSH_C;
            if (rnd) next_y_dir = -y_dir;
        end else if (dx < MARGIN_NEG) begin
            next_x_dir = -x_dir;
            next_x     = ball_x - PUSH_C;
            if (rnd) next_y_dir = -y_dir;
        end else if (dy > MARGIN_POS) begin
            next_y_dir = -y_dir;
            next_y     = ball_y + PUSH_C;
            if (rnd) next_x_dir = -x_dir;
        end else if (dy < MARGIN_NEG) begin
            next_y_dir = -y_dir;
            next_y     = ball_y - PUSH_C;
            if (rnd) next_x_dir = -x_dir;
        end else begin
            if (dx == '0 || dy == '0) begin
                next_x_dir = -x_dir;
                next_y_dir = -y_dir;
            end else if (dx[DW-1] != dy[DW-1]) begin
                next_x_dir = y_dir;
                next_y_dir = x_dir;
            end else begin
                next_x_dir = -y_dir;
                next_y_dir = -x_dir;
            end
            if (dx != '0) next_x = dx[DW-1] ? ball_x - PUSH_C : ball_x + PUSH_C;
            if (dy != '0) next_y = dy[DW-1] ? ball_y - PUSH_C : ball_y + PUSH_C;
        end
    end

endmodule

// File: rtl/ball_controller.sv
// Moves one ball around the arena, bouncing off walls and off NUM_PLAYERS players checked
// one per cycle, with sticky per-player hit flags.
module ball_controller
    import ball_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS        = 4,
    parameter int unsigned COORD_W            = 11,
    parameter int unsigned DIR_W              = 5,
    parameter int          PLAYER_RADIUS      = 20,
    parameter int          BALL_RADIUS        = 8,
    parameter int          SIDE_MARGIN        = 28,
    parameter int          PUSH               = 5,
    parameter int          SPEED              = 2,
    parameter int unsigned MOVEMENT_FREQUENCY = 100000,
    parameter int          START_X            = 450,
    parameter int          START_Y            = 275,
    parameter int          ARENA_LEFT         = 150,
    parameter int          ARENA_RIGHT        = 660,
    parameter int          ARENA_TOP          = 36,
    parameter int          ARENA_BOTTOM       = 510
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             game_initiated,
    input  logic                             game_over,
    input  logic [NUM_PLAYERS*COORD_W-1:0]   player_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0]   player_y,
    input  logic [NUM_PLAYERS-1:0]           hit_clear,
    output logic signed [COORD_W-1:0]        x_position,
    output logic signed [COORD_W-1:0]        y_position,
    output logic [NUM_PLAYERS-1:0]           hit,
    output logic                             moving
);

    localparam int unsigned PTR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned CNT_W = (MOVEMENT_FREQUENCY > 1) ? $clog2(MOVEMENT_FREQUENCY) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVEMENT_FREQUENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PLAYERS - 1);

    localparam logic signed [COORD_W-1:0] X_START     = COORD_W'(START_X);
    localparam logic signed [COORD_W-1:0] Y_START     = COORD_W'(START_Y);
    localparam logic signed [COORD_W-1:0] WALL_TOP    = COORD_W'(ARENA_TOP + BALL_RADIUS);
    localparam logic signed [COORD_W-1:0] WALL_BOTTOM = COORD_W'(ARENA_BOTTOM - BALL_RADIUS);
    localparam logic signed [COORD_W-1:0] WALL_LEFT   = COORD_W'(ARENA_LEFT + BALL_RADIUS);
    localparam logic signed [COORD_W-1:0] WALL_RIGHT  = COORD_W'(ARENA_RIGHT - BALL_RADIUS);
    localparam logic signed [COORD_W-1:0] PUSH_C      = COORD_W'(PUSH);
    localparam logic signed [DIR_W-1:0]   DIR_INIT    = DIR_W'(SPEED);

    state_e                    state_q, state_d;
    logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic signed [DIR_W-1:0]   x_dir_q, x_dir_d, y_dir_q, y_dir_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [NUM_PLAYERS-1:0]    hit_q, hit_d;
    logic [7:0]                lfsr_q, lfsr_d;

    logic [COORD_W-1:0]        px_arr [NUM_PLAYERS];
    logic [COORD_W-1:0]        py_arr [NUM_PLAYERS];
    logic                      rnd;
    logic signed [COORD_W-1:0] x_step, y_step;
    logic                      col_hit;
    logic signed [COORD_W-1:0] col_x, col_y;
    logic signed [DIR_W-1:0]   col_x_dir, col_y_dir;
    logic [NUM_PLAYERS-1:0]    hit_set;

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            px_arr[i] = player_x[i*COORD_W +: COORD_W];
            py_arr[i] = player_y[i*COORD_W +: COORD_W];
        end
    end

    assign rnd    = lfsr_q[0];
    assign x_step = COORD_W'(x_dir_q);
    assign y_step = COORD_W'(y_dir_q);

    ball_collision_unit #(
        .COORD_W      (COORD_W),
        .DIR_W        (DIR_W),
        .PLAYER_RADIUS(PLAYER_RADIUS),
        .BALL_RADIUS  (BALL_RADIUS),
        .SIDE_MARGIN  (SIDE_MARGIN),
        .PUSH         (PUSH)
    ) u_collision (
        .ball_x    (x_q),
        .ball_y    (y_q),
        .x_dir     (x_dir_q),
        .y_dir     (y_dir_q),
        .player_x  (px_arr[ptr_q]),
        .player_y  (py_arr[ptr_q]),
        .rnd       (rnd),
        .hit       (col_hit),
        .next_x    (col_x),
        .next_y    (col_y),
        .next_x_dir(col_x_dir),
        .next_y_dir(col_y_dir)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x_dir_d = x_dir_q;
        y_dir_d = y_dir_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        hit_set = '0;
        lfsr_d  = lfsr_next(lfsr_q);

        unique case (state_q)
            StIdle: begin
                x_d     = X_START;
                y_d     = Y_START;
                x_dir_d = DIR_INIT;
                y_dir_d = DIR_INIT;
                cnt_d   = '0;
                ptr_d   = '0;
                if (game_initiated && !game_over) state_d = StRun;
            end
            StRun: begin
                if (game_over) begin
                    state_d = StIdle;
                    x_d     = X_START;
                    y_d     = Y_START;
                    x_dir_d = DIR_INIT;
                    y_dir_d = DIR_INIT;
                    cnt_d   = '0;
                    ptr_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    x_d   = x_q + x_step;
                    y_d   = y_q + y_step;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Walls take priority; the player scan only advances on check cycles.
                    if (y_q < WALL_TOP) begin
                        y_dir_d = -y_dir_q;
                        y_d     = y_q + PUSH_C;
                        if (rnd) x_dir_d = -x_dir_q;
                    end else if (y_q > WALL_BOTTOM) begin
                        y_dir_d = -y_dir_q;
                        y_d     = y_q - PUSH_C;
                        if (rnd) x_dir_d = -x_dir_q;
                    end else if (x_q < WALL_LEFT) begin
                        x_dir_d = -x_dir_q;
                        x_d     = x_q + PUSH_C;
                        if (rnd) y_dir_d = -y_dir_q;
                    end else if (x_q > WALL_RIGHT) begin
                        x_dir_d = -x_dir_q;
                        x_d     = x_q - PUSH_C;
                        if (rnd) y_dir_d = -y_dir_q;
                    end else begin
                        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
                        if (col_hit) begin
                            x_d     = col_x;
                            y_d     = col_y;
                            x_dir_d = col_x_dir;
                            y_dir_d = col_y_dir;
                            hit_set = NUM_PLAYERS'(1) << ptr_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        hit_d = (hit_q & ~hit_clear) | hit_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= X_START;
            y_q     <= Y_START;
            x_dir_q <= DIR_INIT;
            y_dir_q <= DIR_INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
            hit_q   <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x_dir_q <= x_dir_d;
            y_dir_q <= y_dir_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            hit_q   <= hit_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign x_position = x_q;
    assign y_position = y_q;
    assign hit        = hit_q;
    assign moving     = (state_q == StRun);

endmodule

// File: tb/tb_ball_controller.sv
// Bench for ball_controller: directed table and hand sequences, then random play checked
// cycle by cycle against an integer model of the ball rules.
module tb_ball_controller;
    import ball_pkg::*;

    localparam int NP   = 4;
    localparam int CW   = 11;
    localparam int FREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 gi = 1'b0;
    logic                 go = 1'b0;
    logic [NP*CW-1:0]     player_x = '0;
    logic [NP*CW-1:0]     player_y = '0;
    logic [NP-1:0]        hit_clear = '0;
    coord_t               x_position;
    coord_t               y_position;
    logic [NP-1:0]        hit;
    logic                 moving;

    int n_checks = 0;
    int n_errors = 0;

    ball_controller #(
        .MOVEMENT_FREQUENCY(FREQ)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_initiated(gi),
        .game_over     (go),
        .player_x      (player_x),
        .player_y      (player_y),
        .hit_clear     (hit_clear),
        .x_position    (x_position),
        .y_position    (y_position),
        .hit           (hit),
        .moving        (moving)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int ex, input int ey, input int em,
                                 input int eh);
        check({tag, " x"}, int'(x_position), ex);
        check({tag, " y"}, int'(y_position), ey);
        check({tag, " moving"}, int'(moving), em);
        check({tag, " hit"}, int'(hit), eh);
    endtask

    task automatic set_player(input int i, input int px, input int py);
        player_x[i*CW +: CW] = CW'(px);
        player_y[i*CW +: CW] = CW'(py);
    endtask

    // Reference model: plain integers, rules applied directly.
    int       m_x, m_y, m_xd, m_yd, m_cnt, m_ptr;
    bit       m_run;
    bit [3:0] m_hit;
    bit [7:0] m_lfsr;

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic model_home();
        m_x = 450; m_y = 275; m_xd = 2; m_yd = 2; m_cnt = 0; m_ptr = 0;
    endtask

    task automatic model_clock();
        bit       rnd;
        bit       fb;
        bit [3:0] hset;
        int       px, py, dx, dy, t;
        int       taps [4] = '{8, 6, 5, 4};
        rnd  = m_lfsr[0];
        hset = '0;
        if (rst) begin
            model_home();
            m_run  = 0;
            m_hit  = '0;
            m_lfsr = 8'hA5;
            return;
        end
        if (!m_run) begin
            model_home();
            if (gi && !go) m_run = 1;
        end else if (go) begin
            m_run = 0;
            model_home();
        end else if (m_cnt == FREQ - 1) begin
            m_x += m_xd; m_y += m_yd; m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_y < 36 + 8) begin
                m_yd = -m_yd; m_y += 5; if (rnd) m_xd = -m_xd;
            end else if (m_y > 510 - 8) begin
                m_yd = -m_yd; m_y -= 5; if (rnd) m_xd = -m_xd;
            end else if (m_x < 150 + 8) begin
                m_xd = -m_xd; m_x += 5; if (rnd) m_yd = -m_yd;
            end else if (m_x > 660 - 8) begin
                m_xd = -m_xd; m_x -= 5; if (rnd) m_yd = -m_yd;
            end else begin
                px = int'(player_x[m_ptr*CW +: CW]);
                py = int'(player_y[m_ptr*CW +: CW]);
                dx = m_x - px;
                dy = m_y - py;
                if (dx * dx + dy * dy < 30 * 30) begin
                    hset[m_ptr] = 1'b1;
                    if (dx > 28) begin
                        m_xd = -m_xd; m_x += 5; if (rnd) m_yd = -m_yd;
                    end else if (dx < -28) begin
                        m_xd = -m_xd; m_x -= 5; if (rnd) m_yd = -m_yd;
                    end else if (dy > 28) begin
                        m_yd = -m_yd; m_y += 5; if (rnd) m_xd = -m_xd;
                    end else if (dy < -28) begin
                        m_yd = -m_yd; m_y -= 5; if (rnd) m_xd = -m_xd;
                    end else begin
                        if (dx == 0 || dy == 0) begin
                            m_xd = -m_xd; m_yd = -m_yd;
                        end else if ((dx < 0) != (dy < 0)) begin
                            t = m_xd; m_xd = m_yd; m_yd = t;
                        end else begin
                            t = m_xd; m_xd = -m_yd; m_yd = -t;
                        end
                        m_x += 5 * sgn(dx);
                        m_y += 5 * sgn(dy);
                    end
                end
                m_ptr = (m_ptr + 1) % NP;
            end
        end
        m_hit = (m_hit & ~hit_clear) | hset;
        fb = 1'b0;
        foreach (taps[k]) fb ^= m_lfsr[taps[k] - 1];
        m_lfsr = {m_lfsr[6:0], fb};
    endtask

    typedef struct {
        bit rst;
        bit gi;
        bit go;
        int cycles;
        int ex;
        int ey;
        int em;
        int eh;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1, 0, 0, 1, 450, 275, 0, 0};   // reset
        vecs[1] = '{0, 0, 0, 50, 450, 275, 0, 0};  // idle hold
        vecs[2] = '{0, 1, 0, 1, 450, 275, 1, 0};   // start
        vecs[3] = '{0, 1, 0, 4, 452, 277, 1, 0};   // first step
        vecs[4] = '{0, 0, 0, 4, 454, 279, 1, 0};   // second step, start is a level
        vecs[5] = '{0, 1, 1, 1, 450, 275, 0, 0};   // both high: stop wins
        vecs[6] = '{0, 1, 1, 3, 450, 275, 0, 0};   // both high in idle: no start
        vecs[7] = '{0, 0, 0, 10, 450, 275, 0, 0};
        vecs[8] = '{0, 1, 0, 9, 454, 279, 1, 0};   // restart: two steps

        foreach (vecs[i]) begin
            rst = vecs[i].rst; gi = vecs[i].gi; go = vecs[i].go;
            for (int c = 0; c < vecs[i].cycles; c++) tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].em,
                          vecs[i].eh);
        end

        // Same-sign diagonal hit on the first check cycle, then flag clear/set corners.
        rst = 1'b1; gi = 1'b0; go = 1'b0;
        tick();
        rst = 1'b0; gi = 1'b1;
        set_player(0, 435, 260);
        tick();                                   // enter RUN
        gi = 1'b0;
        tick();                                   // check player 0
        check_outputs("diag", 455, 280, 1, 4'b0001);
        set_player(0, 0, 0);
        repeat (3) tick();                        // two far checks, then step with (-2,-2)
        check_outputs("diag_step", 453, 278, 1, 4'b0001);
        hit_clear = 4'b0001;
        tick();
        hit_clear = 4'b0000;
        check_outputs("clear0", 453, 278, 1, 4'b0000);
        repeat (3) tick();                        // checks of players 0,1 then step
        check_outputs("step2", 451, 276, 1, 4'b0000);
        set_player(2, 436, 261);                  // player 2 is next in the scan
        hit_clear = 4'b0100;
        tick();
        hit_clear = 4'b0000;
        set_player(2, 0, 0);
        check_outputs("set_beats_clear", 456, 281, 1, 4'b0100);
        go = 1'b1;
        tick();
        go = 1'b0;
        check_outputs("stop", 450, 275, 0, 4'b0100);
        hit_clear = 4'b0100;
        tick();
        hit_clear = 4'b0000;
        check_outputs("clear_idle", 450, 275, 0, 4'b0000);

        // Random play against the model.
        rst = 1'b1;
        model_clock();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            rst = ($urandom_range(0, 5999) == 0);
            go  = ($urandom_range(0, 2999) == 0);
            gi  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NP; i++) begin
                hit_clear[i] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 63) == 0) begin
                    if ($urandom_range(0, 1) == 0) begin
                        set_player(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
                    end else begin
                        set_player(i, (m_x > 40) ? m_x - 34 + int'($urandom_range(0, 68)) : 0,
                                   (m_y > 40) ? m_y - 34 + int'($urandom_range(0, 68)) : 0);
                    end
                end
            end
            model_clock();
            tick();
            check_outputs($sformatf("rand%0d", cyc), m_x, m_y, int'(m_run), int'(m_hit));
            if (n_errors > 40) break;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
